// File: rtl/sort_serializer.sv
// -----------------------------------------------------------------------------
// sort_serializer
//
// Purpose:
//   Downstream stage of the 4-entry sorter. It captures the four ranked values
//   on the sorter's one-cycle done strobe. It then replays each captured frame
//   as an AXI-stream packet of four beats, largest value first, and honours
//   TREADY backpressure. A two-slot ping-pong buffer holds up to two frames,
//   so the sorter can deliver a new frame while the previous one is still
//   draining.
//
// Parameters:
//   DATA_WIDTH  width of each ranked value and of m_tdata (default 16)
//
// Ports:
//   clk        in   ACLK, single clock domain
//   rst        in   ARESETn, asynchronous assert, active low
//   lvl1..lvl4 in   sorted values from the sorter, lvl1 = largest
//   done       in   one-cycle strobe, lvl1..lvl4 valid this cycle
//   m_tdata    out  output word (0 while idle)
//   m_tvalid   out  TVALID
//   m_tready   in   TREADY
//   m_tuser    out  start of frame, high on word 0 only
//   m_tlast    out  end of frame, high on word 3 only
//   busy       out  at least one frame buffered (same as m_tvalid)
//   ovf        out  sticky, a done strobe was dropped because both slots were
//                   full; cleared only by reset
//
// Configuration:
//   SORT_SERIALIZER_STATS_EN defined adds two status outputs:
//     frm_cnt   out 16  frames fully sent, wraps 0xFFFF -> 0
//     drop_cnt  out 16  done strobes dropped, saturates at 0xFFFF
//   When the macro is undefined, these ports and counters do not exist.
// -----------------------------------------------------------------------------
module sort_serializer #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] lvl1,
    input  logic [DATA_WIDTH-1:0] lvl2,
    input  logic [DATA_WIDTH-1:0] lvl3,
    input  logic [DATA_WIDTH-1:0] lvl4,
    input  logic                  done,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tuser,
    output logic                  m_tlast,
`ifdef SORT_SERIALIZER_STATS_EN
    output logic [15:0]           frm_cnt,
    output logic [15:0]           drop_cnt,
`endif
    output logic                  busy,
    output logic                  ovf
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_e;

    // Frame storage: two slots of four words each. Word 0 holds lvl1.
    logic [DATA_WIDTH-1:0] slot_q [2][4];

    state_e      state_q;
    logic        valid_q;    // registered TVALID, set and cleared with state_q
    logic [1:0]  count_q;    // frames buffered, 0..2
    logic [1:0]  count_d;
    logic        wr_ptr_q;   // slot that receives the next accepted frame
    logic        rd_ptr_q;   // slot currently being replayed
    logic [1:0]  idx_q;      // word index within the frame being replayed
    logic        ovf_q;

    logic        hs;         // beat handshake this cycle
    logic        pop;        // final-beat handshake, which frees a slot
    logic        push;       // done strobe accepted into a slot
    logic        drop;       // done strobe refused because both slots are full
    logic [1:0]  count_after_pop;

    // -------------------------------------------------------------------------
    // Push/pop decisions.
    // The pop is applied before the push. If the last beat of a frame leaves
    // in the same cycle that a new frame arrives, the freed slot takes the new
    // frame, even when both slots were full at the start of that cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // through the block leaves one unassigned and infers a latch.
        hs              = 1'b0;
        pop             = 1'b0;
        push            = 1'b0;
        drop            = 1'b0;
        count_after_pop = count_q;
        count_d         = count_q;

        hs              = valid_q & m_tready;
        pop             = hs & (idx_q == 2'd3);
        count_after_pop = count_q - {1'b0, pop};
        push            = done & (count_after_pop != 2'd2);
        drop            = done & ~push;
        count_d         = count_after_pop + {1'b0, push};
    end

    // -------------------------------------------------------------------------
    // Slot write port.
    // NOTE: the frame storage has no reset. The occupancy count and the
    // pointers decide which slots hold valid data, and m_tdata is forced to
    // zero while nothing is valid. The array can therefore stay plain RAM/flops
    // without reset fan-out.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            slot_q[wr_ptr_q][0] <= lvl1;
            slot_q[wr_ptr_q][1] <= lvl2;
            slot_q[wr_ptr_q][2] <= lvl3;
            slot_q[wr_ptr_q][3] <= lvl4;
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM and buffer bookkeeping.
    // IDLE moves to SEND in the same edge that accepts the first frame. The
    // frame's word 0 is therefore on the bus one cycle after done. SEND
    // returns to IDLE only after the final beat of the last buffered frame
    // has handshaked, so TVALID never drops without a handshake.
    // NOTE: sequential state is updated only with non-blocking assignments.
    // Every register then samples values from before the edge, whatever order
    // the statements appear in.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            valid_q  <= 1'b0;
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            idx_q    <= 2'd0;
            ovf_q    <= 1'b0;
        end else begin
            count_q <= count_d;

            if (push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end

            if (drop) begin
                ovf_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    idx_q <= 2'd0;
                    if (count_d != 2'd0) begin
                        state_q <= S_SEND;
                        valid_q <= 1'b1;
                    end
                end

                S_SEND: begin
                    if (hs) begin
                        if (idx_q == 2'd3) begin
                            idx_q    <= 2'd0;
                            rd_ptr_q <= ~rd_ptr_q;
                            // The next frame follows with no gap if one is
                            // waiting, or was accepted in this same edge.
                            if (count_d == 2'd0) begin
                                state_q <= S_IDLE;
                                valid_q <= 1'b0;
                            end
                        end else begin
                            idx_q <= idx_q + 2'd1;
                        end
                    end
                end

                default: begin
                    state_q <= S_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef SORT_SERIALIZER_STATS_EN
    // -------------------------------------------------------------------------
    // Statistics. The frame counter wraps. The drop counter saturates, so it
    // never reads low after a long overflow storm.
    // -------------------------------------------------------------------------
    logic [15:0] frm_cnt_q;
    logic [15:0] drop_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frm_cnt_q  <= 16'd0;
            drop_cnt_q <= 16'd0;
        end else begin
            if (pop) begin
                frm_cnt_q <= frm_cnt_q + 16'd1;
            end
            if (drop && (drop_cnt_q != 16'hFFFF)) begin
                drop_cnt_q <= drop_cnt_q + 16'd1;
            end
        end
    end

    assign frm_cnt  = frm_cnt_q;
    assign drop_cnt = drop_cnt_q;
`endif

    // -------------------------------------------------------------------------
    // Outputs. Each one comes from registers only; there is no path from done
    // or lvl* to the stream. The data mux is gated with valid_q, so the bus
    // reads zero while idle and returns to zero as soon as reset asserts.
    // -------------------------------------------------------------------------
    assign m_tvalid = valid_q;
    assign m_tdata  = valid_q ? slot_q[rd_ptr_q][idx_q] : '0;
    assign m_tuser  = valid_q & (idx_q == 2'd0);
    assign m_tlast  = valid_q & (idx_q == 2'd3);
    assign busy     = valid_q;
    assign ovf      = ovf_q;

endmodule
